// File: rtl/exp_ascii_seq.sv
// Exponent stage of the float-to-decimal path: removes the bias, converts the magnitude
// to decimal by repeated subtraction, and streams "E<sign><digits>". Macro EXP_FIXED_WIDTH_EN forces three digits.
module exp_ascii_seq #(
  parameter int EXP_W = 8,
  parameter int BIAS  = 127
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_char,
  output logic             out_last,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, LOAD, DIV100, DIV10, EMIT} state_t;
  typedef enum logic [2:0] {CH_E, CH_SIGN, CH_H, CH_T, CH_U} pos_t;

  localparam logic [EXP_W-1:0] BIAS_V = EXP_W'(BIAS);
  localparam logic [EXP_W-1:0] C100   = EXP_W'(100);
  localparam logic [EXP_W-1:0] C10    = EXP_W'(10);

`ifdef EXP_FIXED_WIDTH_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  state_t           state_q, state_d;
  pos_t             pos_q, pos_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [EXP_W-1:0] rem_q, rem_d;
  logic             neg_q, neg_d;
  logic [3:0]       h_q, h_d;
  logic [3:0]       t_q, t_d;
  logic             in_ready_q, in_ready_d;
  logic             show_h, show_t;

  assign show_h = FIXED || (h_q != 4'd0);
  assign show_t = FIXED || (h_q != 4'd0) || (t_q != 4'd0);

  // NOTE: every register gets a non-blocking assignment so all state updates see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pos_q      <= CH_E;
      exp_q      <= '0;
      rem_q      <= '0;
      neg_q      <= 1'b0;
      h_q        <= 4'd0;
      t_q        <= 4'd0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      exp_q      <= exp_d;
      rem_q      <= rem_d;
      neg_q      <= neg_d;
      h_q        <= h_d;
      t_q        <= t_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_comb begin
    // NOTE: hold-value defaults first, so no path through the case can infer a latch.
    state_d = state_q;
    pos_d   = pos_q;
    exp_d   = exp_q;
    rem_d   = rem_q;
    neg_d   = neg_q;
    h_d     = h_q;
    t_d     = t_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          exp_d   = in_exp;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (exp_q >= BIAS_V) begin
          neg_d = 1'b0;
          rem_d = exp_q - BIAS_V;
        end else begin
          neg_d = 1'b1;
          rem_d = BIAS_V - exp_q;
        end
        h_d     = 4'd0;
        t_d     = 4'd0;
        state_d = DIV100;
      end
      DIV100: begin
        if (rem_q >= C100) begin
          rem_d = rem_q - C100;
          h_d   = h_q + 4'd1;
        end else begin
          state_d = DIV10;
        end
      end
      DIV10: begin
        if (rem_q >= C10) begin
          rem_d = rem_q - C10;
          t_d   = t_q + 4'd1;
        end else begin
          state_d = EMIT;
          pos_d   = CH_E;
        end
      end
      EMIT: begin
        if (out_ready) begin
          // Leading-zero suppression is decided when leaving the sign character.
          case (pos_q)
            CH_E:    pos_d = CH_SIGN;
            CH_SIGN: pos_d = show_h ? CH_H : (show_t ? CH_T : CH_U);
            CH_H:    pos_d = CH_T;
            CH_T:    pos_d = CH_U;
            default: state_d = IDLE;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready is registered from the next state so it rises on the edge that returns to IDLE.
  assign in_ready_d = (state_d == IDLE);

  assign in_ready  = in_ready_q;
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == EMIT);
  assign out_last  = out_valid && (pos_q == CH_U);

  always_comb begin
    out_char = 8'h00;
    if (state_q == EMIT) begin
      case (pos_q)
        CH_E:    out_char = 8'h45;
        CH_SIGN: out_char = neg_q ? 8'h2D : 8'h2B;
        CH_H:    out_char = 8'h30 + {4'h0, h_q};
        CH_T:    out_char = 8'h30 + {4'h0, t_q};
        default: out_char = 8'h30 + {4'h0, rem_q[3:0]};
      endcase
    end
  end

endmodule

// File: tb/tb_exp_ascii_seq.sv
// Directed bench for exp_ascii_seq: an arithmetic model fills a character scoreboard on
// each accepted exponent; characters are popped and compared as the DUT transfers them.
module tb_exp_ascii_seq;

  typedef struct {
    logic [7:0] ch;
    logic       last;
  } exp_char_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_exp;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_char;
  logic       out_last;
  logic       busy;

  exp_char_t  sb_q[$];
  int         checks;
  int         errors;

  exp_ascii_seq #(.EXP_W(8), .BIAS(127)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_exp    (in_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_char  (out_char),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Fills the scoreboard for one exponent and returns the expected accept-to-valid latency.
  function automatic int push_expected(input logic [7:0] e);
    int  mag;
    int  h;
    int  t;
    int  u;
    bit  neg;
    neg = (int'(e) < 127);
    mag = neg ? 127 - int'(e) : int'(e) - 127;
    h   = mag / 100;
    t   = (mag / 10) % 10;
    u   = mag % 10;
    sb_q.push_back('{8'h45, 1'b0});
    sb_q.push_back('{neg ? 8'h2D : 8'h2B, 1'b0});
`ifdef EXP_FIXED_WIDTH_EN
    sb_q.push_back('{8'(8'h30 + h), 1'b0});
    sb_q.push_back('{8'(8'h30 + t), 1'b0});
`else
    if (h != 0) sb_q.push_back('{8'(8'h30 + h), 1'b0});
    if (h != 0 || t != 0) sb_q.push_back('{8'(8'h30 + t), 1'b0});
`endif
    sb_q.push_back('{8'(8'h30 + u), 1'b1});
    return 3 + h + t;
  endfunction

  // stall: cycles out_ready is held low on the sign character.
  // poke: hold in_valid high during emission, which must be ignored.
  // abort_at: character index at which rst is pulsed (-1 = never).
  task automatic run_field(input logic [7:0] e, input int stall, input bit poke, input int abort_at);
    int cyc;
    int idx;
    int lat;
    int stall_left;
    exp_char_t c;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    check($sformatf("ready_before_%0h", e), 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_exp    = e;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = push_expected(e);
    check($sformatf("ready_drop_%0h", e), 32'(in_ready), 32'd0);
    check($sformatf("busy_%0h", e), 32'(busy), 32'd1);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    check($sformatf("latency_%0h", e), 32'(cyc), 32'(lat));
    if (poke) begin
      in_valid = 1'b1;
      in_exp   = 8'h00;
    end
    idx = 0;
    cyc = 0;
    stall_left = stall;
    while (sb_q.size() > 0 && cyc < 50) begin
      c = sb_q[0];
      check($sformatf("valid_%0h_%0d", e, idx), 32'(out_valid), 32'd1);
      check($sformatf("char_%0h_%0d", e, idx), 32'(out_char), 32'(c.ch));
      check($sformatf("last_%0h_%0d", e, idx), 32'(out_last), 32'(c.last));
      if (idx == abort_at) begin
        #2 rst = 1'b1;
        #1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(in_ready), 32'd0);
        check("abort_char", 32'(out_char), 32'd0);
        sb_q.delete();
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_ready_held", 32'(in_ready), 32'd0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        check("abort_ready_rise", 32'(in_ready), 32'd1);
        check("abort_idle", 32'(busy), 32'd0);
        return;
      end
      if (idx == 1 && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
        if (c.last) in_valid = 1'b0;
        void'(sb_q.pop_front());
        idx++;
      end
      @(posedge clk); #1; cyc++;
    end
    check($sformatf("drained_%0h", e), 32'(sb_q.size()), 32'd0);
    check($sformatf("end_valid_%0h", e), 32'(out_valid), 32'd0);
    check($sformatf("end_ready_%0h", e), 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check($sformatf("stay_idle_%0h", e), 32'(busy), 32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_exp    = 8'h00;
    out_ready = 1'b0;

    #2 rst = 1'b1;
    #1;
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_char", 32'(out_char), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("rst_ready_held", 32'(in_ready), 32'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("rel_ready", 32'(in_ready), 32'd1);

    run_field(8'h80, 0, 1'b0, -1);
    run_field(8'h2F, 0, 1'b0, -1);
    run_field(8'h7F, 0, 1'b0, -1);
    run_field(8'h00, 0, 1'b0, -1);
    run_field(8'hFF, 0, 1'b0, -1);
    run_field(8'h8A, 3, 1'b1, -1);
    run_field(8'h8A, 0, 1'b0, 2);
    run_field(8'h80, 0, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
